// File: rtl/result_sel_pkg.sv
// Shared types and constants for the recognition result selector.
package result_sel_pkg;

    localparam int SCORE_W_DEF = 24;
    localparam int WORD_W_DEF  = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2,
        ACK     = 2'd3
    } state_t;

    localparam logic [WORD_W_DEF-1:0]  NO_WORD   = {WORD_W_DEF{1'b1}};
    localparam logic [SCORE_W_DEF-1:0] SCORE_MIN = {1'b1, {(SCORE_W_DEF-1){1'b0}}};

endpackage

// File: rtl/result_cmp.sv
// Signed compare-and-keep-best unit; strict compare so ties keep the earlier index.
module result_cmp
    import result_sel_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int WORD_W  = WORD_W_DEF
) (
    input  logic                      en,
    input  logic signed [SCORE_W-1:0] score,
    input  logic        [WORD_W-1:0]  idx,
    input  logic signed [SCORE_W-1:0] best_in,
    input  logic        [WORD_W-1:0]  best_idx_in,
    output logic signed [SCORE_W-1:0] best_out,
    output logic        [WORD_W-1:0]  best_idx_out
);

    // Replace the running best only on a strictly greater score.
    always_comb begin
        best_out     = best_in;
        best_idx_out = best_idx_in;
        if (en && (score > best_in)) begin
            best_out     = score;
            best_idx_out = idx;
        end else begin
            best_out     = best_in;
            best_idx_out = best_idx_in;
        end
    end

endmodule

// File: rtl/result_sel.sv
// Best-word result selector between the HMM decoder, host and parameter loader.
// Optional idle watchdog enabled by defining RESULT_TIMEOUT_EN.
module result_sel
    import result_sel_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int WORD_W  = WORD_W_DEF
`ifdef RESULT_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 65535
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic        [WORD_W-1:0]  word_num,
    input  logic                      ready,
    input  logic                      fs,
    input  logic                      score_valid,
    input  logic signed [SCORE_W-1:0] score,
    input  logic        [WORD_W-1:0]  score_word,
    input  logic                      host_ack,
    output logic                      result_valid,
    output logic        [WORD_W-1:0]  result_word,
    output logic signed [SCORE_W-1:0] result_score,
    output logic                      result_ack,
    output logic                      busy,
    output logic                      seq_err
`ifdef RESULT_TIMEOUT_EN
    , output logic                    timeout
`endif
);

    localparam logic [WORD_W-1:0]  NO_WORD_L   = {WORD_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_MIN_L = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic [WORD_W:0]    CNT_ONE     = {{WORD_W{1'b0}}, 1'b1};

    state_t                      state_r, state_next_s;
    logic                        fs_d_r, arm_r, start_s, hit_s, last_s, tmo_hit_s;
    logic        [WORD_W:0]      count_r;
    logic signed [SCORE_W-1:0]   best_r, cmp_best_s;
    logic        [WORD_W-1:0]    best_idx_r, cmp_idx_s;
    logic                        result_valid_r, result_ack_r, busy_r, seq_err_r;
    logic        [WORD_W-1:0]    result_word_r;
    logic signed [SCORE_W-1:0]   result_score_r;

    // arm_r blocks a start until fs has been seen low since reset, so a stuck-high fs cannot start a pass.
    assign start_s = fs && !fs_d_r && ready && arm_r;
    assign hit_s   = (state_r == COLLECT) && score_valid && ({1'b0, score_word} == count_r);
    assign last_s  = hit_s && (count_r == ({1'b0, word_num} - CNT_ONE));

    result_cmp #(.SCORE_W(SCORE_W), .WORD_W(WORD_W)) u_cmp (
        .en           (hit_s),
        .score        (score),
        .idx          (score_word),
        .best_in      (best_r),
        .best_idx_in  (best_idx_r),
        .best_out     (cmp_best_s),
        .best_idx_out (cmp_idx_s)
    );

`ifdef RESULT_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    logic [IDLE_W-1:0] idle_r;
    logic              timeout_r;

    assign tmo_hit_s = (state_r == COLLECT) && !score_valid && (idle_r == IDLE_LAST);

    // Idle watchdog: cleared by each strobe, flags a timed-out pass until the next start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_r    <= {IDLE_W{1'b0}};
            timeout_r <= 1'b0;
        end else if ((state_r == IDLE) && start_s) begin
            idle_r    <= {IDLE_W{1'b0}};
            timeout_r <= 1'b0;
        end else if (state_r == COLLECT) begin
            idle_r <= score_valid ? {IDLE_W{1'b0}} : (idle_r + {{(IDLE_W-1){1'b0}}, 1'b1});
            if (tmo_hit_s && fs) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign timeout = timeout_r;
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_next_s = (word_num == {WORD_W{1'b0}}) ? HOLD : COLLECT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            COLLECT: begin
                if (!fs) begin
                    state_next_s = IDLE;
                end else if (last_s || tmo_hit_s) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = COLLECT;
                end
            end
            HOLD: begin
                if (host_ack) begin
                    state_next_s = ACK;
                end else begin
                    state_next_s = HOLD;
                end
            end
            ACK:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Score collection, result capture and handshake registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fs_d_r         <= 1'b0;
            arm_r          <= 1'b0;
            count_r        <= {(WORD_W+1){1'b0}};
            best_r         <= SCORE_MIN_L;
            best_idx_r     <= NO_WORD_L;
            result_valid_r <= 1'b0;
            result_word_r  <= NO_WORD_L;
            result_score_r <= {SCORE_W{1'b0}};
            result_ack_r   <= 1'b0;
            busy_r         <= 1'b0;
            seq_err_r      <= 1'b0;
        end else begin
            fs_d_r       <= fs;
            arm_r        <= arm_r || !fs;
            busy_r       <= (state_next_s == COLLECT);
            result_ack_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        count_r        <= {(WORD_W+1){1'b0}};
                        best_r         <= SCORE_MIN_L;
                        best_idx_r     <= NO_WORD_L;
                        seq_err_r      <= 1'b0;
                        result_word_r  <= NO_WORD_L;
                        result_score_r <= {SCORE_W{1'b0}};
                        result_valid_r <= (word_num == {WORD_W{1'b0}});
                    end
                end
                COLLECT: begin
                    if (hit_s) begin
                        best_r     <= cmp_best_s;
                        best_idx_r <= cmp_idx_s;
                        count_r    <= count_r + CNT_ONE;
                    end else if (score_valid) begin
                        seq_err_r <= 1'b1;
                    end
                    if (state_next_s == HOLD) begin
                        result_valid_r <= 1'b1;
                        result_word_r  <= cmp_idx_s;
                        result_score_r <= cmp_best_s;
                    end
                end
                HOLD: begin
                    if (score_valid) begin
                        seq_err_r <= 1'b1;
                    end
                    result_ack_r <= host_ack;
                end
                ACK: begin
                    result_valid_r <= 1'b0;
                end
                default: begin
                    result_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign result_valid = result_valid_r;
    assign result_word  = result_word_r;
    assign result_score = result_score_r;
    assign result_ack   = result_ack_r;
    assign busy         = busy_r;
    assign seq_err      = seq_err_r;

endmodule

// File: doc/result_sel.md
Name: result_sel

Overview:
Recognition result selector, directly downstream of the HMM decoder and the model-parameter loader.
- Collects one log-likelihood score per vocabulary word while a decode pass runs (fs high).
- Tracks the best-scoring word index and presents it to the host.
- After the host accepts the result, pulses result_ack back to the parameter loader, which clears fs and re-arms front-end feature extraction.

Parameters:
SCORE_W, 24, width of signed two's-complement log-likelihood score
WORD_W, 6, width of word index; matches word_num from parameter loader
TIMEOUT_CYC, 65535, idle-cycle limit for watchdog (used only with RESULT_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
word_num  in  WORD_W  vocabulary size from parameter loader; valid when ready=1
ready  in  1  parameter loader finished loading model parameters
fs  in  1  decode phase active (from parameter loader)
score_valid  in  1  one-cycle strobe: score/score_word valid
score  in  SCORE_W  signed word log-likelihood
score_word  in  WORD_W  word index of score
host_ack  in  1  host has read result (level or pulse)
result_valid  out  1  result_word/result_score stable and valid
result_word  out  WORD_W  best word index; all-ones = no result
result_score  out  SCORE_W  best score
result_ack  out  1  one-cycle pulse to parameter loader
busy  out  1  state is COLLECT
seq_err  out  1  sticky: out-of-order or excess score seen in current pass

Behaviour:
- Reset (async, active-low): state=IDLE; result_valid=0, result_word=all-ones, result_score=0, result_ack=0, busy=0, seq_err=0, count=0, fs_d=0.
- fs_d registers fs every cycle. start = fs & ~fs_d & ready.
- IDLE:
  - On start: count<=0; best<=most-negative (1 followed by SCORE_W-1 zeros); best_idx<=all-ones; seq_err<=0; result_valid<=0; go to COLLECT.
  - If start occurs with word_num==0: go directly to HOLD with result_word=all-ones, result_valid=1.
  - fs rising while ready=0: ignored.
- COLLECT (busy=1):
  - On score_valid with score_word==count:
    - If score > best (signed, strict), update best and best_idx. Ties keep the earlier, lower index.
    - count<=count+1.
    - If count==word_num-1, then next cycle: state=HOLD, result_valid=1, result_word=best_idx (including the update from this cycle), result_score=best.
  - score_valid with score_word!=count: seq_err<=1, score ignored, count unchanged.
  - score_valid outside COLLECT: seq_err<=1 only if in HOLD; otherwise ignored.
  - fs falling during COLLECT (aborted pass): go to IDLE, result_valid stays 0, no result_ack.
- HOLD: outputs held stable. When host_ack=1, go to ACK.
- ACK:
  - result_ack=1 for exactly one cycle; result_valid<=0; state<=IDLE.
  - result_word/result_score keep their last value until the next start.
- host_ack in any state other than HOLD: ignored.
- Latency: result_valid asserts 1 cycle after the final accepted score_valid. result_ack asserts 1 cycle after host_ack is sampled in HOLD.
- count is WORD_W+1 bits, so word_num=63 does not wrap.
- Re-arm requires fs to fall and rise again, so a stuck-high fs cannot trigger a second pass.

Optional Feature:
RESULT_TIMEOUT_EN
- Defined:
  - An idle counter in COLLECT resets on each score_valid and increments otherwise.
  - On reaching TIMEOUT_CYC: go to HOLD with result_valid=1, result_word=best_idx so far, and an extra output timeout=1. timeout clears on the next start and resets to 0.
- Undefined: no counter, no timeout port; COLLECT waits indefinitely.

Decomposition:
- Shared package: state encoding constants (IDLE=0, COLLECT=1, HOLD=2, ACK=3), NO_WORD all-ones constant, SCORE_W and WORD_W defaults, SCORE_MIN constant.
- One sub-module: result_cmp, the combinational/registered signed compare-and-keep-best unit (score, best, idx in; best, idx out), reusable for the N-best extension.

Test Plan:
- word_num=4, scores {-100,-20,-50,-20} for indices 0..3, then host_ack -> result_word=1, result_score=-20, result_valid 1 cycle after 4th strobe, single result_ack pulse.
- ready=1, fs rising with word_num=0 -> HOLD next cycle, result_word=63, result_valid=1, no scores consumed.
- word_num=3, strobes with score_word 0,2,1,2 -> seq_err=1 after second strobe; pass completes after indices 0,1,2; result correct.
- fs dropped mid-COLLECT after 2 of 5 scores -> IDLE, result_valid=0, result_ack never asserted; next fs rise starts a clean pass.
- reset asserted in HOLD with result_valid=1 -> all outputs return to reset values asynchronously; fs held high after reset release does not start a pass until it toggles.
- With RESULT_TIMEOUT_EN and TIMEOUT_CYC=16: word_num=5, 2 scores then silence -> HOLD after 16 idle cycles, timeout=1, result_word=best of 2.
